// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: selects the next PC by priority, buffers
// redirects that arrive during a stall, range-checks targets and counts fetches.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
   parameter int unsigned IMEM_WORDS = 4096,
   parameter logic [31:0] EXC_VEC    = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic        stall,
   input  logic        redir_valid,
   input  logic [31:0] redir_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic        pc_we,
   output logic [31:0] npc,
   output logic        fetch_valid,
   output logic        flush,
   output logic        redir_pending,
   output logic        ifault,
   output logic [31:0] bad_addr,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_HOLD
   } state_t;

   // The bounds are compared in 33 bits so that a memory ending exactly at 2^32 still works.
   localparam logic [32:0] IMEM_LO = {1'b0, IMEM_BASE};
   localparam logic [32:0] IMEM_HI = IMEM_LO + 33'(64'(IMEM_WORDS) * 64'd4);

   function automatic logic is_legal(input logic [31:0] addr);
      return (addr[1:0] == 2'b00) && ({1'b0, addr} >= IMEM_LO) && ({1'b0, addr} < IMEM_HI);
   endfunction

   state_t      state_q,    state_d;
   logic [31:0] pend_q,     pend_d;
   logic        flush_q,    flush_d;
   logic        ifault_q,   ifault_d;
   logic [31:0] bad_addr_q, bad_addr_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   logic        take;
   logic [31:0] take_tgt;
   logic        kill;
   logic        fault;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      pend_d      = pend_q;
      pc_we       = 1'b0;
      npc         = pc_in + 32'd4;
      fetch_valid = (state_q != ST_BOOT) && !stall;
      take        = 1'b0;
      take_tgt    = 32'h0;
      kill        = 1'b0;

      case (state_q)
         ST_BOOT: begin
            npc     = RESET_PC;
            state_d = ST_RUN;
         end
         default: begin
            if (exc_req) begin
               pc_we   = 1'b1;
               npc     = EXC_VEC;
               kill    = 1'b1;
               state_d = ST_RUN;
               pend_d  = 32'h0;
            end else if (eret_req) begin
               take     = 1'b1;
               take_tgt = epc;
               kill     = 1'b1;
               state_d  = ST_RUN;
               pend_d   = 32'h0;
            end else if (redir_valid && !stall) begin
               take     = 1'b1;
               take_tgt = redir_target;
               state_d  = ST_RUN;
               pend_d   = 32'h0;
            end else if (redir_valid) begin
               pend_d  = redir_target;
               state_d = ST_HOLD;
            end else if (state_q == ST_HOLD && !stall) begin
               take     = 1'b1;
               take_tgt = pend_q;
               state_d  = ST_RUN;
               pend_d   = 32'h0;
            end else if (!stall) begin
               pc_we = 1'b1;
            end
         end
      endcase

      // Any taken target that falls outside instruction memory diverts to the handler.
      fault = take && !is_legal(take_tgt);
      if (take) begin
         pc_we = 1'b1;
         npc   = fault ? EXC_VEC : take_tgt;
      end

      flush_d     = kill || fault;
      ifault_d    = fault;
      bad_addr_d  = fault ? take_tgt : bad_addr_q;
      fetch_cnt_d = fetch_cnt_q + 32'(pc_we);
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_BOOT;
         pend_q      <= 32'h0;
         flush_q     <= 1'b0;
         ifault_q    <= 1'b0;
         bad_addr_q  <= 32'h0;
         fetch_cnt_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         flush_q     <= flush_d;
         ifault_q    <= ifault_d;
         bad_addr_q  <= bad_addr_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign redir_pending = (state_q == ST_HOLD);
   assign flush         = flush_q;
   assign ifault        = ifault_q;
   assign bad_addr      = bad_addr_q;
   assign fetch_cnt     = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a behavioural model checked every falling edge,
// plus literal expectations at the key points of each scenario.
module tb_fetch_ctrl;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
   localparam int unsigned IMEM_WORDS = 4096;
   localparam logic [31:0] EXC_VEC    = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic        stall, redir_valid, exc_req, eret_req;
   logic [31:0] redir_target, epc;
   logic        pc_we, fetch_valid, flush, redir_pending, ifault;
   logic [31:0] npc, bad_addr, fetch_cnt;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   fetch_ctrl #(
      .RESET_PC  (RESET_PC),
      .IMEM_BASE (IMEM_BASE),
      .IMEM_WORDS(IMEM_WORDS),
      .EXC_VEC   (EXC_VEC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_in        (pc_in),
      .stall        (stall),
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .exc_req      (exc_req),
      .eret_req     (eret_req),
      .epc          (epc),
      .pc_we        (pc_we),
      .npc          (npc),
      .fetch_valid  (fetch_valid),
      .flush        (flush),
      .redir_pending(redir_pending),
      .ifault       (ifault),
      .bad_addr     (bad_addr),
      .fetch_cnt    (fetch_cnt)
   );

   // Model state: booting flag, holding flag with its saved target, registered outputs, fetch-unit PC.
   bit          m_boot, m_hold, m_flush, m_ifault;
   logic [31:0] m_pend, m_bad, m_cnt, f_pc;
   bit          e_we, e_fv, e_fault, e_kill, e_hold_n;
   logic [31:0] e_npc, e_pend_n, e_tgt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_legal(input logic [31:0] a);
      longint unsigned lo = longint'(IMEM_BASE);
      longint unsigned hi = lo + 4 * longint'(IMEM_WORDS);
      return (a % 4 == 0) && (longint'(a) >= lo) && (longint'(a) < hi);
   endfunction

   function automatic void use_target(input logic [31:0] t);
      e_we    = 1'b1;
      e_tgt   = t;
      e_fault = !m_legal(t);
      e_npc   = e_fault ? EXC_VEC : t;
   endfunction

   function automatic void model_eval();
      e_we = 1'b0; e_npc = pc_in + 32'd4; e_fv = !m_boot && !stall;
      e_fault = 1'b0; e_kill = 1'b0; e_tgt = 32'h0;
      e_hold_n = m_hold; e_pend_n = m_pend;
      if (m_boot) e_npc = RESET_PC;
      else if (exc_req) begin
         e_we = 1'b1; e_npc = EXC_VEC; e_kill = 1'b1; e_hold_n = 1'b0;
      end else if (eret_req) begin
         use_target(epc); e_kill = 1'b1; e_hold_n = 1'b0;
      end else if (redir_valid && !stall) begin
         use_target(redir_target); e_hold_n = 1'b0;
      end else if (redir_valid) begin
         e_hold_n = 1'b1; e_pend_n = redir_target;
      end else if (m_hold && !stall) begin
         use_target(m_pend); e_hold_n = 1'b0;
      end else if (!stall) e_we = 1'b1;
   endfunction

   function automatic void model_reset();
      m_boot = 1'b1; m_hold = 1'b0; m_flush = 1'b0; m_ifault = 1'b0;
      m_pend = 32'h0; m_bad = 32'h0; m_cnt = 32'h0; f_pc = RESET_PC;
   endfunction

   function automatic void model_advance();
      if (reset) model_reset();
      else begin
         model_eval();
         m_flush  = e_kill || e_fault;
         m_ifault = e_fault;
         if (e_fault) m_bad = e_tgt;
         if (e_we) begin
            m_cnt = m_cnt + 32'd1;
            f_pc  = e_npc;
         end
         m_boot = 1'b0;
         m_hold = e_hold_n;
         m_pend = e_pend_n;
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         model_eval();
         check("pc_we",         32'(pc_we),         32'(e_we));
         check("npc",           npc,                e_npc);
         check("fetch_valid",   32'(fetch_valid),   32'(e_fv));
         check("redir_pending", 32'(redir_pending), 32'(m_hold));
         check("flush",         32'(flush),         32'(m_flush));
         check("ifault",        32'(ifault),        32'(m_ifault));
         check("bad_addr",      bad_addr,           m_bad);
         check("fetch_cnt",     fetch_cnt,          m_cnt);
      end
   end

   task automatic drive(input bit s, input bit rv, input logic [31:0] rt,
                        input bit ex, input bit er, input logic [31:0] ep);
      stall = s; redir_valid = rv; redir_target = rt;
      exc_req = ex; eret_req = er; epc = ep; pc_in = f_pc;
      #2;
   endtask

   task automatic adv();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      stall = 1'b0; redir_valid = 1'b0; redir_target = 32'h0;
      exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;
      model_reset();
      pc_in = f_pc;
      #1 chk_en = 1'b1;
      adv(); adv();

      // Boot cycle, then sequential fetch.
      reset = 1'b0;
      idle();
      check("boot_we",  32'(pc_we), 32'd0);
      check("boot_npc", npc,        32'h0000_3000);
      adv();
      idle();
      check("seq1_npc", npc, 32'h0000_3004);
      check("seq1_we",  32'(pc_we), 32'd1);
      adv();
      idle();
      check("seq2_npc", npc, 32'h0000_3008);
      adv();
      check("cnt_two", fetch_cnt, 32'd2);
      idle(); adv();
      idle(); adv();

      // Unstalled redirect from 0x3010.
      drive(1'b0, 1'b1, 32'h0000_3040, 1'b0, 1'b0, 32'h0);
      check("redir_pcin", pc_in, 32'h0000_3010);
      check("redir_npc",  npc,   32'h0000_3040);
      adv();
      check("redir_noflush", 32'(flush),         32'd0);
      check("redir_nopend",  32'(redir_pending), 32'd0);

      // Redirect buffered across a 3-cycle stall.
      drive(1'b1, 1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h0);
      check("hold_we0", 32'(pc_we), 32'd0);
      adv();
      check("hold_pend", 32'(redir_pending), 32'd1);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
         check("hold_we", 32'(pc_we), 32'd0);
         adv();
      end
      idle();
      check("release_npc", npc, 32'h0000_3100);
      check("release_we",  32'(pc_we), 32'd1);
      adv();
      check("release_pend", 32'(redir_pending), 32'd0);

      // Exception overrides stall and pending redirect; then exception return.
      drive(1'b1, 1'b1, 32'h0000_3200, 1'b0, 1'b0, 32'h0);
      adv();
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      check("exc_npc", npc, 32'h0000_4180);
      check("exc_we",  32'(pc_we), 32'd1);
      adv();
      check("exc_flush", 32'(flush),         32'd1);
      check("exc_pend",  32'(redir_pending), 32'd0);
      idle(); adv();
      check("exc_flush_once", 32'(flush), 32'd0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3020);
      check("eret_npc", npc, 32'h0000_3020);
      adv();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3020);
      check("exc_over_eret", npc, 32'h0000_4180);
      adv();

      // Target range checks, including the edges of instruction memory.
      drive(1'b0, 1'b1, 32'h0000_3002, 1'b0, 1'b0, 32'h0);
      check("misalign_npc", npc, 32'h0000_4180);
      adv();
      check("misalign_ifault", 32'(ifault), 32'd1);
      check("misalign_bad",    bad_addr,    32'h0000_3002);
      idle(); adv();
      check("ifault_pulse", 32'(ifault), 32'd0);
      drive(1'b0, 1'b1, 32'h0000_7000, 1'b0, 1'b0, 32'h0);
      check("past_end_npc", npc, 32'h0000_4180);
      adv();
      check("past_end_bad", bad_addr, 32'h0000_7000);
      drive(1'b0, 1'b1, 32'h0000_6FFC, 1'b0, 1'b0, 32'h0);
      check("last_word_npc", npc, 32'h0000_6FFC);
      adv();
      check("last_word_held", bad_addr, 32'h0000_7000);
      drive(1'b0, 1'b1, 32'h0000_2FFC, 1'b0, 1'b0, 32'h0);
      adv();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1000);
      check("bad_epc_npc", npc, 32'h0000_4180);
      adv();
      drive(1'b1, 1'b1, 32'h0000_7004, 1'b0, 1'b0, 32'h0);
      adv();
      idle();
      check("bad_pend_npc", npc, 32'h0000_4180);
      adv();
      check("bad_pend_bad", bad_addr, 32'h0000_7004);

      // Sequential PC wraps at 2^32.
      f_pc = 32'hFFFF_FFFC;
      idle();
      check("wrap_npc", npc, 32'h0000_0000);
      adv();

      // Asynchronous reset in the middle of HOLD.
      drive(1'b1, 1'b1, 32'h0000_3300, 1'b0, 1'b0, 32'h0);
      adv();
      check("prereset_pend", 32'(redir_pending), 32'd1);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      reset = 1'b1;
      model_reset();
      pc_in = f_pc;
      #1;
      check("arst_pend", 32'(redir_pending), 32'd0);
      check("arst_we",   32'(pc_we),         32'd0);
      check("arst_npc",  npc,                32'h0000_3000);
      check("arst_cnt",  fetch_cnt,          32'd0);
      check("arst_bad",  bad_addr,           32'd0);
      adv(); adv();
      reset = 1'b0;
      idle();
      check("reboot_npc", npc, 32'h0000_3000);
      adv();
      idle();
      check("reboot_seq", npc, 32'h0000_3004);
      adv();
      idle(); adv();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the fetch stage. It owns the PC write-enable and next-PC value presented to the instruction-fetch unit, and selects the next PC by priority: exception vector, exception return, branch/jump redirect, sequential PC+4. It buffers a redirect that arrives while the pipeline is stalled and range-checks every redirect target. It also flags fetch-bubble cycles and counts committed fetches for the performance/debug path.

Parameters:
RESET_PC, 32'h0000_3000, PC value driven during and after reset
IMEM_BASE, 32'h0000_3000, first byte address of instruction memory
IMEM_WORDS, 4096, instruction memory depth in 32-bit words
EXC_VEC, 32'h0000_4180, exception handler entry address

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pc_in  input  32  current PC from the fetch unit
stall  input  1  hazard-unit stall request; hold PC
redir_valid  input  1  branch/jump taken, resolved this cycle
redir_target  input  32  redirect target address
exc_req  input  1  exception accepted; vector to EXC_VEC
eret_req  input  1  exception return
epc  input  32  return address for eret_req
pc_we  output  1  write enable to the fetch unit PC register
npc  output  32  next PC to the fetch unit
fetch_valid  output  1  0 marks the fetched instruction as a bubble
flush  output  1  one-cycle pulse; kill F/D register contents
redir_pending  output  1  buffered redirect waiting for stall release
ifault  output  1  one-cycle pulse; bad redirect/eret target
bad_addr  output  32  last faulting target, held until next fault or reset
fetch_cnt  output  32  count of cycles with pc_we=1, wraps at 2^32

Behaviour:
- Reset (asynchronous): state=BOOT, pc_we=0, npc=RESET_PC, fetch_valid=0, flush=0, redir_pending=0, ifault=0, bad_addr=0, fetch_cnt=0, pending target register=0.
- States are BOOT, RUN, and HOLD (stalled with a buffered redirect).
- BOOT lasts exactly one cycle after reset deasserts. In BOOT: pc_we=0, npc=RESET_PC, fetch_valid=0. Next state is RUN, unconditionally.
- npc and pc_we are combinational from the state and inputs. ifault, flush, bad_addr and fetch_cnt are registered, so each appears or updates one cycle after the qualifying edge.
- Target legality: a target is legal when addr[1:0]==0 and IMEM_BASE <= addr < IMEM_BASE+4*IMEM_WORDS.
- An illegal redir_target or epc is replaced by EXC_VEC. It then sets ifault for one cycle, captures the address into bad_addr, and pulses flush.
- Priority in RUN and HOLD:
  - exc_req: npc=EXC_VEC, pc_we=1 even if stall=1. flush pulses and the pending redirect is cleared. Next state is RUN.
  - else eret_req: same handling as exc_req, but npc=epc.
  - else redir_valid with stall=0: npc=redir_target, pc_we=1. The pending redirect is cleared.
  - else redir_valid with stall=1: pc_we=0. The target is latched into the pending register, overwriting any older value. Next state is HOLD.
  - else in HOLD with stall=0: npc=pending target, pc_we=1. Next state is RUN.
  - else stall=1: pc_we=0 and npc=pc_in+4. The state is unchanged.
  - else: npc=pc_in+4 (32-bit, wraps), pc_we=1.
- exc_req and eret_req asserted together: exc_req wins and eret_req is ignored.
- redir_pending=1 exactly while in HOLD.
- fetch_valid=0 in BOOT and in any cycle with stall=1. Otherwise fetch_valid=1.
- The instruction already fetched when a redirect is taken (the delay slot) is not flushed. Only exc_req, eret_req and ifault pulse flush.
- Reset asserted mid-HOLD discards the pending target immediately. No redirect survives reset.

Test Plan:
- Reset release, no stall → cycle 1 BOOT (pc_we=0, npc=0x3000); then npc=0x3004, 0x3008 with pc_we=1; fetch_cnt=2 after two RUN edges.
- redir_valid=1, target=0x3040, stall=0 at pc_in=0x3010 → npc=0x3040, pc_we=1, no flush, redir_pending=0.
- stall=1 for 3 cycles with redir_valid=1, target=0x3100, on the first cycle → pc_we=0 for 3 cycles, redir_pending=1; on stall release npc=0x3100, pc_we=1, redir_pending=0.
- exc_req=1 together with stall=1 and a pending redirect → npc=0x4180, pc_we=1, flush pulses once, redir_pending drops to 0; eret_req=1 with epc=0x3020 → npc=0x3020.
- redir_target=0x3002 and then 0x7000 → each time npc=0x4180, ifault pulses, bad_addr=0x3002 then 0x7000.
- Assert reset asynchronously mid-HOLD (between clock edges) → all outputs take reset values without waiting for a clock edge; after release, the first non-BOOT npc is 0x3004, not the old pending target.
